// File: rtl/acc_dma_pkg.sv
// Shared constants and state encoding for the accelerator DMA read engine.
package acc_dma_pkg;

    // Fixed AXI encodings used by the read master.
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_32B   = 3'b101;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Default beat geometry: one 256-bit beat carries 32 bytes.
    localparam int DATA_W_DEF = 256;
    localparam int BEAT_BYTES = DATA_W_DEF / 8;

    // Engine control states, also exported on the debug port.
    typedef enum logic [1:0] {
        DMA_IDLE = 2'd0,
        DMA_BUSY = 2'd1,
        DMA_DONE = 2'd2
    } dma_state_e;

endpackage

// File: rtl/dma_rd_engine_if.sv
// Bundle of command, AXI read (AR/R) and downstream stream signals.
//
// Handshake rule for every valid/ready pair in this bundle: a transfer
// happens on a rising clk edge where valid and ready are both 1; once a
// source raises valid it holds valid and its payload unchanged until that
// transfer, and valid never waits on ready.
interface dma_rd_engine_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int CNT_W  = 16
);
    // Command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [CNT_W-1:0]  cmd_rows;
    logic [ADDR_W-1:0] cmd_stride;

    // AXI read address channel
    logic [ADDR_W-1:0] m_araddr;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic [1:0]        m_arburst;
    logic              m_arvalid;
    logic              m_arready;

    // AXI read data channel
    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast;
    logic              m_rvalid;
    logic              m_rready;

    // Downstream stream and status
    logic [DATA_W-1:0] dma_data;
    logic              dma_valid;
    logic              dma_rlast;
    logic              dma_ready;
    logic              dma_done;
    logic              dma_err;

    // Engine side
    modport master (
        input  cmd_valid, cmd_addr, cmd_rows, cmd_stride,
        output cmd_ready,
        output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        input  m_arready,
        input  m_rdata, m_rresp, m_rlast, m_rvalid,
        output m_rready,
        output dma_data, dma_valid, dma_rlast,
        input  dma_ready,
        output dma_done, dma_err
    );

    // Environment side: command issuer, AXI slave and downstream consumer
    modport slave (
        output cmd_valid, cmd_addr, cmd_rows, cmd_stride,
        input  cmd_ready,
        input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        output m_arready,
        output m_rdata, m_rresp, m_rlast, m_rvalid,
        input  m_rready,
        input  dma_data, dma_valid, dma_rlast,
        output dma_ready,
        input  dma_done, dma_err
    );

endinterface

// File: rtl/dma_rd_engine_ar_gen.sv
// AR address generator: walks base + n*stride and limits outstanding bursts.
module dma_ar_gen
    import acc_dma_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 16,
    parameter int MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,      // command accepted this cycle
    input  logic              run,        // engine is BUSY next cycle
    input  logic [ADDR_W-1:0] base_addr,  // already beat aligned
    input  logic [ADDR_W-1:0] stride,     // already beat aligned
    input  logic [CNT_W-1:0]  rows,       // row count valid next cycle
    input  logic [CNT_W:0]    rows_done,  // completed rows, next-cycle value
    input  logic              ar_ready,
    output logic [ADDR_W-1:0] ar_addr,
    output logic              ar_valid
);

    localparam logic [CNT_W:0] MAX_OUT_C = (CNT_W+1)'(MAX_OUT);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [CNT_W:0]    issued_q, issued_d;
    logic              arvalid_q, arvalid_d;
    logic              ar_hs;

    assign ar_hs = arvalid_q & ar_ready;

    // Next address / issue count, and whether another burst may be offered.
    always_comb begin
        addr_d   = addr_q;
        stride_d = stride_q;
        issued_d = issued_q;
        if (start) begin
            addr_d   = base_addr;
            stride_d = stride;
            issued_d = '0;
        end else if (ar_hs) begin
            addr_d   = addr_q + stride_q;
            issued_d = issued_q + (CNT_W+1)'(1);
        end
        arvalid_d = run && (issued_d < {1'b0, rows}) &&
                    ((issued_d - rows_done) < MAX_OUT_C);
        // A stalled request is never withdrawn.
        if (arvalid_q && !ar_ready && run) begin
            arvalid_d = 1'b1;
        end
    end

    // Register the AR request so address/valid are glitch-free and stable.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr_q    <= '0;
            stride_q  <= '0;
            issued_q  <= '0;
            arvalid_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            stride_q  <= stride_d;
            issued_q  <= issued_d;
            arvalid_q <= arvalid_d;
        end
    end

    assign ar_addr  = addr_q;
    assign ar_valid = arvalid_q;

endmodule

// File: rtl/dma_rd_engine.sv
// Strided-burst AXI4 read master: one fixed-length burst per row, beats
// streamed straight through to the accelerator buffer stage.
module dma_rd_engine
    import acc_dma_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256,
    parameter int BEATS   = 2,
    parameter int MAX_OUT = 2,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    dma_rd_engine_if.master       bus,
    output dma_state_e            dbg_state
);

    // Low address bits inside one beat are dropped from addr and stride.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(DATA_W / 8 - 1);

    dma_state_e        state_q, state_d;
    logic [CNT_W-1:0]  rows_q, rows_d;
    logic [CNT_W:0]    rows_done_q, rows_done_d;
    logic              err_q, err_d;

    logic busy;
    logic cmd_acc;
    logic beat_acc;
    logic last_acc;

    assign busy     = (state_q == DMA_BUSY);
    assign cmd_acc  = bus.cmd_valid && (state_q == DMA_IDLE);
    assign beat_acc = bus.m_rvalid && busy && bus.dma_ready;
    assign last_acc = beat_acc && bus.m_rlast;

    // Control FSM next state, row completion count and sticky error.
    always_comb begin
        state_d     = state_q;
        rows_d      = rows_q;
        rows_done_d = rows_done_q;
        err_d       = err_q;
        case (state_q)
            DMA_IDLE: begin
                if (bus.cmd_valid) begin
                    rows_d      = bus.cmd_rows;
                    rows_done_d = '0;
                    err_d       = 1'b0;
                    state_d     = (bus.cmd_rows == '0) ? DMA_DONE : DMA_BUSY;
                end
            end
            DMA_BUSY: begin
                if (last_acc) begin
                    rows_done_d = rows_done_q + (CNT_W+1)'(1);
                end
                if (beat_acc && (bus.m_rresp != AXI_RESP_OKAY)) begin
                    err_d = 1'b1;
                end
                // Leave on the edge that accepts the final beat so done
                // follows that beat by one cycle.
                if (rows_done_d == {1'b0, rows_q}) begin
                    state_d = DMA_DONE;
                end
            end
            DMA_DONE: begin
                state_d = DMA_IDLE;
            end
            default: begin
                state_d = DMA_IDLE;
            end
        endcase
    end

    // Control state registers; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= DMA_IDLE;
            rows_q      <= '0;
            rows_done_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            rows_done_q <= rows_done_d;
            err_q       <= err_d;
        end
    end

    dma_ar_gen #(
        .ADDR_W  (ADDR_W),
        .CNT_W   (CNT_W),
        .MAX_OUT (MAX_OUT)
    ) u_ar_gen (
        .clk       (clk),
        .rstn      (rstn),
        .start     (cmd_acc),
        .run       (state_d == DMA_BUSY),
        .base_addr (bus.cmd_addr & ALIGN_MASK),
        .stride    (bus.cmd_stride & ALIGN_MASK),
        .rows      (rows_d),
        .rows_done (rows_done_d),
        .ar_ready  (bus.m_arready),
        .ar_addr   (bus.m_araddr),
        .ar_valid  (bus.m_arvalid)
    );

    assign bus.m_arlen   = 8'(BEATS - 1);
    assign bus.m_arsize  = AXI_SIZE_32B;
    assign bus.m_arburst = AXI_BURST_INCR;

    // R channel is a pure passthrough gated by the BUSY state.
    assign bus.m_rready  = busy && bus.dma_ready;
    assign bus.dma_data  = bus.m_rdata;
    assign bus.dma_valid = bus.m_rvalid && busy;
    assign bus.dma_rlast = bus.m_rlast && bus.m_rvalid && busy;

    assign bus.cmd_ready = (state_q == DMA_IDLE);
    assign bus.dma_done  = (state_q == DMA_DONE);
    assign bus.dma_err   = err_q;

    assign dbg_state = state_q;

endmodule

// File: tb/tb_dma_rd_engine.sv
// Self-checking bench for dma_rd_engine: AXI slave model, behavioural
// reference of the command/stream rules, and per-cycle comparison.
module tb_dma_rd_engine;
    import acc_dma_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 256;
    localparam int BEATS   = 2;
    localparam int MAX_OUT = 2;
    localparam int CNT_W   = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dma_rd_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
    dma_state_e dbg_state;

    dma_rd_engine #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS),
        .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Beat payload the slave returns: command tag and beat index, replicated.
    function automatic logic [DATA_W-1:0] beat_word(input int tag, input int idx);
        return {8{tag[15:0], idx[15:0]}};
    endfunction

    // ---------------- stimulus knobs ----------------
    int cmd_tag = 0;
    int flush_req = 0;
    int r_hold_until = 0;
    int err_beat = -1;
    bit ar_rand = 0, r_rand = 0, err_rand = 0;
    int rdy_mode = 0;   // 0: always ready, 1: toggle, 2: random

    // ---------------- AXI slave model ----------------
    int sl_pend = 0, sl_beat = 0, sl_tag = 0, flush_seen = 0;
    bit sl_active = 0;

    task automatic slave_loop();
        forever begin
            @(posedge clk);
            cyc++;
            if (flush_req != flush_seen) begin
                flush_seen = flush_req;
                sl_pend    = 0;
                sl_active  = 0;
                sl_beat    = 0;
            end else begin
                if (bus.m_arvalid && bus.m_arready) sl_pend++;
                if (sl_active && bus.m_rvalid && bus.m_rready) begin
                    sl_active = 0;
                    if (bus.m_rlast) sl_pend--;
                    sl_beat++;
                end
            end
            if (cmd_tag != sl_tag) begin
                sl_tag  = cmd_tag;
                sl_beat = 0;
            end
            #1;
            bus.m_arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            case (rdy_mode)
                1:       bus.dma_ready = ~bus.dma_ready;
                2:       bus.dma_ready = ($urandom_range(0, 3) != 0);
                default: bus.dma_ready = 1'b1;
            endcase
            if (!sl_active && sl_pend > 0 && cyc >= r_hold_until &&
                (!r_rand || $urandom_range(0, 2) != 0)) begin
                sl_active   = 1;
                bus.m_rdata = beat_word(sl_tag, sl_beat);
                bus.m_rlast = ((sl_beat % BEATS) == BEATS - 1);
                bus.m_rresp = (sl_beat == err_beat || (err_rand && $urandom_range(0, 9) == 0)) ? 2'b10 : 2'b00;
            end
            bus.m_rvalid = sl_active;
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    int m_phase = 0;      // 0 idle, 1 fetching, 2 done pulse
    int m_rows = 0, m_issued = 0, m_done = 0;
    bit m_err = 0;
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] ar_log[$];

    // Per-command observations for the pinned checks.
    int accept_cyc = 0, last_acc_cyc = 0, done_cyc = 0, done_pulses = 0;
    int ar_cnt_cmd = 0, ar_before_rlast = 0, beats_cmd = 0, rlast_cmd = 0;
    bit arvalid_seen = 0, seen_rlast = 0, err_at_done = 0;
    logic [DATA_W-1:0] last_data;

    task automatic monitor_loop();
        bit e_busy, e_arv, ar_hs, r_acc;
        dma_state_e exp_st;
        logic [ADDR_W-1:0] a, s;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                m_phase = 0; m_rows = 0; m_issued = 0; m_done = 0; m_err = 0;
                exp_addr_q.delete();
                exp_q.delete();
            end else begin
                e_busy = (m_phase == 1);
                e_arv  = e_busy && (m_issued < m_rows) && ((m_issued - m_done) < MAX_OUT);
                exp_st = (m_phase == 0) ? DMA_IDLE : (m_phase == 1) ? DMA_BUSY : DMA_DONE;
                chk_i("cmd_ready", int'(bus.cmd_ready), int'(m_phase == 0));
                chk_i("dma_done", int'(bus.dma_done), int'(m_phase == 2));
                chk_i("dma_err", int'(bus.dma_err), int'(m_err));
                chk_i("dbg_state", int'(dbg_state), int'(exp_st));
                chk_i("m_arvalid", int'(bus.m_arvalid), int'(e_arv));
                chk_i("m_rready", int'(bus.m_rready), int'(e_busy && bus.dma_ready));
                chk_i("dma_valid", int'(bus.dma_valid), int'(e_busy && bus.m_rvalid));
                chk_i("dma_rlast", int'(bus.dma_rlast), int'(e_busy && bus.m_rvalid && bus.m_rlast));
                if (e_busy && bus.m_rvalid) chk("dma_data_pass", bus.dma_data, bus.m_rdata);
                if (e_arv && exp_addr_q.size() > 0)
                    chk("m_araddr", DATA_W'(bus.m_araddr), DATA_W'(exp_addr_q[0]));

                ar_hs = e_arv && bus.m_arready;
                r_acc = e_busy && bus.dma_ready && bus.m_rvalid;

                if (ar_hs) begin
                    chk_i("m_arlen", int'(bus.m_arlen), BEATS - 1);
                    chk_i("m_arsize", int'(bus.m_arsize), 5);
                    chk_i("m_arburst", int'(bus.m_arburst), 1);
                    if (exp_addr_q.size() > 0) void'(exp_addr_q.pop_front());
                    ar_log.push_back(bus.m_araddr);
                    m_issued++;
                    ar_cnt_cmd++;
                    if (!seen_rlast) ar_before_rlast++;
                end
                if (r_acc) begin
                    if (exp_q.size() > 0) chk("beat_data", bus.dma_data, exp_q.pop_front());
                    else chk_i("beat_unexpected", 1, 0);
                    last_data = bus.dma_data;
                    beats_cmd++;
                    if (bus.m_rresp != 2'b00) m_err = 1;
                    if (bus.m_rlast) begin
                        m_done++;
                        rlast_cmd++;
                        seen_rlast   = 1;
                        last_acc_cyc = cyc;
                    end
                end
                if (bus.m_arvalid) arvalid_seen = 1;
                if (bus.dma_done) begin
                    done_cyc    = cyc;
                    err_at_done = bus.dma_err;
                    done_pulses++;
                end

                case (m_phase)
                    0: if (bus.cmd_valid) begin
                        m_rows = int'(bus.cmd_rows);
                        m_issued = 0; m_done = 0; m_err = 0;
                        accept_cyc = cyc;
                        ar_cnt_cmd = 0; ar_before_rlast = 0; beats_cmd = 0; rlast_cmd = 0;
                        arvalid_seen = 0; seen_rlast = 0;
                        a = bus.cmd_addr & ~32'h1f;
                        s = bus.cmd_stride & ~32'h1f;
                        for (int i = 0; i < m_rows; i++) begin
                            exp_addr_q.push_back(a);
                            a = a + s;
                        end
                        for (int j = 0; j < m_rows * BEATS; j++) exp_q.push_back(beat_word(cmd_tag, j));
                        m_phase = (m_rows == 0) ? 2 : 1;
                    end
                    1: if (m_done == m_rows) m_phase = 2;
                    default: m_phase = 0;
                endcase
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue_cmd(input logic [ADDR_W-1:0] a, input int rows, input logic [ADDR_W-1:0] s);
        int n;
        cmd_tag++;
        bus.cmd_addr   = a;
        bus.cmd_rows   = CNT_W'(rows);
        bus.cmd_stride = s;
        bus.cmd_valid  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cmd_ready && n < 200);
        chk_i("cmd_accept_seen", int'(bus.cmd_ready), 1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [ADDR_W-1:0] a, input int rows, input logic [ADDR_W-1:0] s);
        int n;
        issue_cmd(a, rows, s);
        n = 0;
        while (!bus.dma_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk_i("dma_done_seen", int'(bus.dma_done), 1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int start, n, pulses;
        logic [ADDR_W-1:0] basic_exp[4];
        bus.cmd_valid = 0; bus.cmd_addr = '0; bus.cmd_rows = '0; bus.cmd_stride = '0;
        bus.m_arready = 1; bus.m_rdata = '0; bus.m_rresp = '0; bus.m_rlast = 0; bus.m_rvalid = 0;
        bus.dma_ready = 1;
        last_data = '0;
        fork
            slave_loop();
            monitor_loop();
        join_none

        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk_i("rst_cmd_ready", int'(bus.cmd_ready), 1);
        chk_i("rst_arvalid", int'(bus.m_arvalid), 0);
        chk_i("rst_rready", int'(bus.m_rready), 0);
        chk_i("rst_done", int'(bus.dma_done), 0);
        chk_i("rst_err", int'(bus.dma_err), 0);
        chk_i("rst_state", int'(dbg_state), int'(DMA_IDLE));
        @(posedge clk);
        #1;

        // Basic four-row fetch with a zero-latency slave.
        basic_exp = '{32'h1000, 32'h1400, 32'h1800, 32'h1C00};
        start = ar_log.size();
        run_cmd(32'h1000, 4, 32'h400);
        chk_i("basic_ar_count", ar_cnt_cmd, 4);
        for (int i = 0; i < 4; i++)
            if (start + i < ar_log.size()) chk("basic_ar_addr", DATA_W'(ar_log[start + i]), DATA_W'(basic_exp[i]));
        chk_i("basic_beats", beats_cmd, 8);
        chk_i("basic_rlasts", rlast_cmd, 4);
        chk_i("basic_done_latency", done_cyc - last_acc_cyc, 1);
        chk("basic_last_data", last_data, beat_word(cmd_tag, 7));

        // Misaligned base and stride are truncated to beat alignment.
        start = ar_log.size();
        run_cmd(32'h1013, 2, 32'h21);
        chk_i("misalign_ar_count", ar_cnt_cmd, 2);
        if (start + 1 < ar_log.size()) begin
            chk("misalign_ar0", DATA_W'(ar_log[start]), DATA_W'(32'h1000));
            chk("misalign_ar1", DATA_W'(ar_log[start + 1]), DATA_W'(32'h1020));
        end

        // Outstanding limit while the slave holds back R data.
        r_hold_until = cyc + 22;
        run_cmd(32'h8000, 5, 32'h100);
        chk_i("outst_before_rlast", ar_before_rlast, 2);
        chk_i("outst_total", ar_cnt_cmd, 5);
        r_hold_until = 0;

        // Downstream backpressure toggling every cycle.
        rdy_mode = 1;
        run_cmd(32'h4000, 3, 32'h40);
        chk_i("bp_beats", beats_cmd, 6);
        chk("bp_last_data", last_data, beat_word(cmd_tag, 5));
        rdy_mode = 0;

        // SLVERR on the second beat: sticky through done, cleared by next command.
        err_beat = 1;
        run_cmd(32'h2000, 2, 32'h80);
        chk_i("err_at_done", int'(err_at_done), 1);
        err_beat = -1;
        run_cmd(32'h2000, 1, 32'h80);
        chk_i("err_cleared", int'(err_at_done), 0);

        // Zero rows: immediate done, no AR traffic.
        run_cmd(32'h3000, 0, 32'h40);
        chk_i("zero_done_latency", done_cyc - accept_cyc, 1);
        chk_i("zero_no_arvalid", int'(arvalid_seen), 0);

        // Reset after the first of four rows completes.
        r_rand = 1;
        issue_cmd(32'h5000, 4, 32'h200);
        n = 0;
        while (m_done < 1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk_i("mid_first_row", int'(m_done >= 1), 1);
        @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        pulses = done_pulses;
        @(negedge clk);
        chk_i("mid_cmd_ready", int'(bus.cmd_ready), 1);
        chk_i("mid_arvalid", int'(bus.m_arvalid), 0);
        chk_i("mid_rready", int'(bus.m_rready), 0);
        repeat (12) @(negedge clk);
        chk_i("mid_no_done", done_pulses - pulses, 0);
        flush_req++;
        repeat (2) @(posedge clk);
        #1;

        // Randomised commands with random slave and consumer timing.
        ar_rand = 1; err_rand = 1; rdy_mode = 2;
        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(1, 6);
            run_cmd($urandom, n, $urandom_range(0, 32'hffff));
            chk_i("rand_ar_count", ar_cnt_cmd, n);
            chk_i("rand_beats", beats_cmd, n * BEATS);
        end
        ar_rand = 0; err_rand = 0; r_rand = 0; rdy_mode = 0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
